// File: rtl/param_stack.sv
// param_stack: DEPTH x WIDTH data stack executing one push/pop/replace/ALU/dup/swap op per clock.
// Define PARAM_STACK_GUARD_EN to reject ops that would overflow or underflow the stack.
module param_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_next,
    output logic [PTR_W:0]   o_depth,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_fault,
    output logic             o_error
);
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_REPL     = 3'd3,
        OP_POP2PUSH = 3'd4,
        OP_DUP      = 3'd5,
        OP_SWAP     = 3'd6,
        OP_RSVD     = 3'd7
    } op_t;

    // With the guard the pointer needs one extra bit to represent a full stack.
`ifdef PARAM_STACK_GUARD_EN
    localparam int SP_W = PTR_W + 1;
`else
    localparam int SP_W = PTR_W;
`endif
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;

    op_t              w_op;
    logic [PTR_W-1:0] w_a0;
    logic [PTR_W-1:0] w_a1;
    logic [PTR_W-1:0] w_a2;
    logic [WIDTH-1:0] w_m1;
    logic [WIDTH-1:0] w_m2;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_lt_full;
    logic             w_ok;
    logic [SP_W-1:0]  w_sp_nxt;
    logic             w_we0;
    logic             w_we1;
    logic [PTR_W-1:0] w_wa0;
    logic [PTR_W-1:0] w_wa1;
    logic [WIDTH-1:0] w_wd0;
    logic [WIDTH-1:0] w_wd1;

    assign w_op = op_t'(i_op);
    assign w_a0 = r_sp[PTR_W-1:0];
    assign w_a1 = w_a0 - PTR_W'(1);
    assign w_a2 = w_a0 - PTR_W'(2);
    assign w_m1 = r_mem[w_a1];
    assign w_m2 = r_mem[w_a2];

`ifdef PARAM_STACK_GUARD_EN
    assign w_ge1     = (r_sp >= SP_ONE);
    assign w_ge2     = (r_sp >= SP_W'(2));
    assign w_lt_full = (r_sp < SP_W'(DEPTH));
`else
    assign w_ge1     = 1'b1;
    assign w_ge2     = 1'b1;
    assign w_lt_full = 1'b1;
`endif

    // Decode into at most two memory writes; SWAP is the only op needing both ports.
    always_comb begin
        w_ok     = 1'b1;
        w_sp_nxt = r_sp;
        w_we0    = 1'b0;
        w_we1    = 1'b0;
        w_wa0    = w_a0;
        w_wa1    = w_a1;
        w_wd0    = i_data;
        w_wd1    = i_data;
        case (w_op)
            OP_PUSH: begin
                w_ok     = w_lt_full;
                w_we0    = 1'b1;
                w_sp_nxt = r_sp + SP_ONE;
            end
            OP_POP: begin
                w_ok     = w_ge1;
                w_sp_nxt = r_sp - SP_ONE;
            end
            OP_REPL: begin
                w_ok  = w_ge1;
                w_we0 = 1'b1;
                w_wa0 = w_a1;
            end
            OP_POP2PUSH: begin
                w_ok     = w_ge2;
                w_we0    = 1'b1;
                w_wa0    = w_a2;
                w_sp_nxt = r_sp - SP_ONE;
            end
            OP_DUP: begin
                w_ok     = w_ge1 & w_lt_full;
                w_we0    = 1'b1;
                w_wd0    = w_m1;
                w_sp_nxt = r_sp + SP_ONE;
            end
            OP_SWAP: begin
                w_ok  = w_ge2;
                w_we0 = 1'b1;
                w_wa0 = w_a1;
                w_wd0 = w_m2;
                w_we1 = 1'b1;
                w_wa1 = w_a2;
                w_wd1 = w_m1;
            end
            default: ;
        endcase
        if (!w_ok) begin
            w_we0    = 1'b0;
            w_we1    = 1'b0;
            w_sp_nxt = r_sp;
        end
    end

    // Storage is never cleared; reset only blocks writes in its own cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset_n && w_we0) r_mem[w_wa0] <= w_wd0;
        if (i_reset_n && w_we1) r_mem[w_wa1] <= w_wd1;
    end

`ifdef PARAM_STACK_GUARD_EN
    logic r_fault;
    logic r_error;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sp    <= '0;
            r_fault <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_fault <= ~w_ok;
            r_error <= r_error | ~w_ok;
        end
    end

    assign o_top   = w_ge1 ? w_m1 : '0;
    assign o_next  = w_ge2 ? w_m2 : '0;
    assign o_depth = r_sp;
    assign o_full  = ~w_lt_full;
    assign o_fault = r_fault;
    assign o_error = r_error;
`else
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sp <= '0;
        end else begin
            r_sp <= w_sp_nxt;
        end
    end

    assign o_top   = w_m1;
    assign o_next  = w_m2;
    assign o_depth = {1'b0, r_sp};
    assign o_full  = 1'b0;
    assign o_fault = 1'b0;
    assign o_error = 1'b0;
`endif

    assign o_empty = (o_depth == '0);

endmodule
